// File: rtl/hs_port_arbiter.sv
// Arbitrates the high-score RAM port between the CPU and queued bridge accesses.
// Optional HS_HALT_LOCK_EN adds halt_lock for exclusive bridge access.
module hs_port_arbiter #(
  parameter int QDEPTH         = 4,
  parameter int MAX_CPU_STREAK = 8
) (
  input  logic                      jb_core_clk,
  input  logic                      reset_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [11:0]               cpu_addr,
  input  logic [7:0]                cpu_wdata,
  output logic                      cpu_ready,
  output logic [7:0]                cpu_rdata,
  output logic                      cpu_rvalid,
  input  logic                      hs_valid,
  input  logic                      hs_we,
  input  logic [11:0]               hs_addr,
  input  logic [7:0]                hs_wdata,
`ifdef HS_HALT_LOCK_EN
  input  logic                      halt_lock,
`endif
  output logic [7:0]                hs_rdata,
  output logic                      hs_rvalid,
  output logic                      hs_overflow,
  output logic [$clog2(QDEPTH):0]   hs_level,
  output logic [11:0]               ram_addr,
  output logic                      ram_we,
  output logic [7:0]                ram_wdata,
  input  logic [7:0]                ram_rdata
);

  localparam int AW = $clog2(QDEPTH);
  localparam int SW = $clog2(MAX_CPU_STREAK + 1);

  typedef enum logic {OWN_CPU = 1'b0, OWN_HS = 1'b1} owner_e;

  logic [11:0]   r_q_addr  [QDEPTH];
  logic [7:0]    r_q_wdata [QDEPTH];
  logic          r_q_we    [QDEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_streak;
  logic          r_overflow;
  logic [11:0]   r_last_addr;
  logic [7:0]    r_last_wdata;
  logic          r_rd_valid;
  owner_e        r_rd_owner;
  logic [7:0]    r_hs_rdata;

  logic          w_empty;
  logic          w_full;
  logic          w_lock;
  logic          w_grant_cpu;
  logic          w_grant_hs;
  logic          w_push_ok;
  logic          w_drop;
  logic          w_cpu_ret;
  logic          w_hs_ret;
  logic [11:0]   w_head_addr;
  logic [7:0]    w_head_wdata;
  logic          w_head_we;

`ifdef HS_HALT_LOCK_EN
  assign w_lock = halt_lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (AW+1)'(QDEPTH));
  assign w_head_addr  = r_q_addr[r_rd_ptr];
  assign w_head_wdata = r_q_wdata[r_rd_ptr];
  assign w_head_we    = r_q_we[r_rd_ptr];

  always_comb begin
    w_grant_cpu = 1'b0;
    w_grant_hs  = 1'b0;
    if (reset_n) begin
      if (w_lock)                                  w_grant_hs  = !w_empty;
      else if (w_empty)                            w_grant_cpu = cpu_req;
      else if (!cpu_req)                           w_grant_hs  = 1'b1;
      else if (r_streak == SW'(MAX_CPU_STREAK))    w_grant_hs  = 1'b1;
      else                                         w_grant_cpu = 1'b1;
    end
  end

  // A push into a full queue survives only when the head leaves this cycle.
  assign w_push_ok = hs_valid && (!w_full || w_grant_hs);
  assign w_drop    = hs_valid &&  w_full && !w_grant_hs;

  always_comb begin
    ram_addr  = r_last_addr;
    ram_wdata = r_last_wdata;
    ram_we    = 1'b0;
    if (w_grant_cpu) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end else if (w_grant_hs) begin
      ram_addr  = w_head_addr;
      ram_wdata = w_head_wdata;
      ram_we    = w_head_we;
    end
  end

  always_ff @(posedge jb_core_clk) begin
    if (w_push_ok) begin
      r_q_addr[r_wr_ptr]  <= hs_addr;
      r_q_wdata[r_wr_ptr] <= hs_wdata;
      r_q_we[r_wr_ptr]    <= hs_we;
    end
  end

  always_ff @(posedge jb_core_clk) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_streak     <= '0;
      r_overflow   <= 1'b0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_owner   <= OWN_CPU;
      r_hs_rdata   <= '0;
    end else begin
      if (w_push_ok)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_grant_hs) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_grant_hs})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow <= r_overflow | w_drop;
      if (w_empty || w_grant_hs)
        r_streak <= '0;
      else if (w_grant_cpu && (r_streak != SW'(MAX_CPU_STREAK)))
        r_streak <= r_streak + 1'b1;
      if (w_grant_cpu || w_grant_hs) begin
        r_last_addr  <= ram_addr;
        r_last_wdata <= ram_wdata;
      end
      r_rd_valid <= (w_grant_cpu && !cpu_we) || (w_grant_hs && !w_head_we);
      r_rd_owner <= w_grant_hs ? OWN_HS : OWN_CPU;
      if (w_hs_ret) r_hs_rdata <= ram_rdata;
    end
  end

  // Return steering is gated by reset_n so a read killed by reset never reports.
  assign w_cpu_ret = reset_n && r_rd_valid && (r_rd_owner == OWN_CPU);
  assign w_hs_ret  = reset_n && r_rd_valid && (r_rd_owner == OWN_HS);

  assign cpu_ready   = w_grant_cpu;
  assign cpu_rvalid  = w_cpu_ret;
  assign cpu_rdata   = w_cpu_ret ? ram_rdata : '0;
  assign hs_rvalid   = w_hs_ret;
  assign hs_rdata    = !reset_n ? '0 : (w_hs_ret ? ram_rdata : r_hs_rdata);
  assign hs_overflow = r_overflow;
  assign hs_level    = r_count;

endmodule

// File: tb/tb_hs_port_arbiter.sv
// Self-checking bench for hs_port_arbiter: RAM model, read-data scoreboards,
// and per-scenario tasks. Halt-lock scenario runs only with HS_HALT_LOCK_EN.
module tb_hs_port_arbiter;
  localparam int QDEPTH = 4;
  localparam int MAXS   = 8;
  localparam int LW     = $clog2(QDEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we;
  logic [11:0]   cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ready, cpu_rvalid;
  logic [7:0]    cpu_rdata;
  logic          hs_valid, hs_we;
  logic [11:0]   hs_addr;
  logic [7:0]    hs_wdata;
  logic [7:0]    hs_rdata;
  logic          hs_rvalid, hs_overflow;
  logic [LW-1:0] hs_level;
  logic [11:0]   ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = '0;
`ifdef HS_HALT_LOCK_EN
  logic          halt_lock = 1'b0;
`endif

  always #5 clk = ~clk;

  hs_port_arbiter #(.QDEPTH(QDEPTH), .MAX_CPU_STREAK(MAXS)) dut (
    .jb_core_clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .hs_valid(hs_valid), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
`ifdef HS_HALT_LOCK_EN
    .halt_lock(halt_lock),
`endif
    .hs_rdata(hs_rdata), .hs_rvalid(hs_rvalid), .hs_overflow(hs_overflow),
    .hs_level(hs_level), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [7:0] mem    [4096];
  logic [7:0] shadow [4096];
  logic [7:0] cpu_q[$];
  logic [7:0] hs_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int cpu_rd_grants = 0;
  int cpu_rvalids = 0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Scoreboard: returns are popped before this cycle's grant is pushed.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (cpu_rvalid) begin
      cpu_rvalids++;
      total_cnt++;
      if (cpu_q.size() == 0)
        $display("FAIL cpu_rdata_sb: got unexpected rvalid data %h, required no return", cpu_rdata);
      else begin
        exp = cpu_q.pop_front();
        if (cpu_rdata !== exp) $display("FAIL cpu_rdata_sb: got %h required %h", cpu_rdata, exp);
        else pass_cnt++;
      end
    end
    if (hs_rvalid) begin
      total_cnt++;
      if (hs_q.size() == 0)
        $display("FAIL hs_rdata_sb: got unexpected rvalid data %h, required no return", hs_rdata);
      else begin
        exp = hs_q.pop_front();
        if (hs_rdata !== exp) $display("FAIL hs_rdata_sb: got %h required %h", hs_rdata, exp);
        else pass_cnt++;
      end
    end
    if (cpu_ready && !cpu_we) begin
      cpu_q.push_back(shadow[cpu_addr]);
      cpu_rd_grants++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    hs_valid = 1'b0; hs_we = 1'b0; hs_addr = '0; hs_wdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Drives one bridge access that the bench knows will be accepted.
  task automatic hs_push(input logic we, input logic [11:0] a, input logic [7:0] d);
    hs_valid = 1'b1; hs_we = we; hs_addr = a; hs_wdata = d;
    if (we) shadow[a] = d;
    else    hs_q.push_back(shadow[a]);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total_cnt++;
    if ({cpu_ready, cpu_rvalid, hs_rvalid, hs_overflow, ram_we} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000", {cpu_ready, cpu_rvalid, hs_rvalid, hs_overflow, ram_we});
    else pass_cnt++;
    total_cnt++;
    if ({hs_level, ram_addr, ram_wdata, cpu_rdata, hs_rdata} !== '0)
      $display("FAIL reset_buses: got lvl=%h addr=%h wd=%h crd=%h hrd=%h required all 0",
               hs_level, ram_addr, ram_wdata, cpu_rdata, hs_rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_bridge_only();
    hs_push(1'b1, 12'h620, 8'hA5);
    @(negedge clk);
    total_cnt++;
    if (ram_we !== 1'b0) $display("FAIL bridge_no_same_cycle: got ram_we=%b required 0", ram_we);
    else pass_cnt++;
    tick();
    hs_push(1'b0, 12'h620, 8'h00);
    @(negedge clk);
    total_cnt++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 12'h620, 8'hA5})
      $display("FAIL bridge_write: got we=%b addr=%h wd=%h required 1/620/a5", ram_we, ram_addr, ram_wdata);
    else pass_cnt++;
    tick();
    hs_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({ram_we, ram_addr, hs_level} !== {1'b0, 12'h620, LW'(1)})
      $display("FAIL bridge_read_issue: got we=%b addr=%h lvl=%0d required 0/620/1", ram_we, ram_addr, hs_level);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({hs_rvalid, hs_rdata} !== {1'b1, 8'hA5})
      $display("FAIL bridge_read_return: got rv=%b data=%h required 1/a5", hs_rvalid, hs_rdata);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({hs_rvalid, hs_rdata, hs_level} !== {1'b0, 8'hA5, LW'(0)})
      $display("FAIL bridge_hold: got rv=%b data=%h lvl=%0d required 0/a5/0", hs_rvalid, hs_rdata, hs_level);
    else pass_cnt++;
    tick();
    // Idle port keeps the last address on the bus.
    @(negedge clk);
    total_cnt++;
    if (ram_addr !== 12'h620) $display("FAIL idle_addr_hold: got %h required 620", ram_addr);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_streak();
    int ready_cnt;
    ready_cnt = 0;
    cpu_rd_grants = 0;
    cpu_rvalids = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h120;
    hs_push(1'b0, 12'h200, 8'h00);
    @(negedge clk);
    total_cnt++;
    if (cpu_ready !== 1'b1) $display("FAIL streak_first: got cpu_ready=%b required 1", cpu_ready);
    else pass_cnt++;
    tick();
    hs_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cpu_addr = 12'h120 + 12'(i);
      @(negedge clk);
      if (cpu_ready === 1'b1) ready_cnt++;
      tick();
    end
    total_cnt++;
    if (ready_cnt !== 8) $display("FAIL streak_cpu_grants: got %0d required 8", ready_cnt);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({cpu_ready, ram_addr} !== {1'b0, 12'h200})
      $display("FAIL streak_bridge_slot: got ready=%b addr=%h required 0/200", cpu_ready, ram_addr);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (cpu_ready !== 1'b1) $display("FAIL streak_resume: got cpu_ready=%b required 1", cpu_ready);
    else pass_cnt++;
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (cpu_rvalids !== cpu_rd_grants || cpu_rd_grants !== 10)
      $display("FAIL streak_rvalid_count: got rvalids=%0d grants=%0d required both 10", cpu_rvalids, cpu_rd_grants);
    else pass_cnt++;
  endtask

  task automatic test_full_pop();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040;
    for (int i = 0; i < 4; i++) begin
      hs_push(1'b0, 12'h300 + 12'(i), 8'h00);
      tick();
    end
    hs_valid = 1'b0;
    for (int i = 4; i < 9; i++) tick();
    hs_push(1'b0, 12'h3F0, 8'h00);
    @(negedge clk);
    total_cnt++;
    if ({cpu_ready, hs_level} !== {1'b0, LW'(4)})
      $display("FAIL full_pop_grant: got ready=%b lvl=%0d required 0/4", cpu_ready, hs_level);
    else pass_cnt++;
    tick();
    hs_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({hs_overflow, hs_level} !== {1'b0, LW'(4)})
      $display("FAIL full_pop_level: got ovf=%b lvl=%0d required 0/4", hs_overflow, hs_level);
    else pass_cnt++;
    cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    total_cnt++;
    if (hs_level !== LW'(0)) $display("FAIL full_pop_drain: got lvl=%0d required 0", hs_level);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0A0;
    for (int i = 0; i < 4; i++) begin
      hs_push(1'b0, 12'h400 + 12'(i), 8'h00);
      tick();
    end
    // Fifth access is expected to be dropped, so it is not scoreboarded.
    hs_valid = 1'b1; hs_we = 1'b0; hs_addr = 12'h4FF;
    @(negedge clk);
    total_cnt++;
    if (cpu_ready !== 1'b1) $display("FAIL ovf_cpu_keeps_port: got %b required 1", cpu_ready);
    else pass_cnt++;
    tick();
    hs_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({hs_overflow, hs_level} !== {1'b1, LW'(4)})
      $display("FAIL ovf_set: got ovf=%b lvl=%0d required 1/4", hs_overflow, hs_level);
    else pass_cnt++;
    tick();
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    total_cnt++;
    if ({hs_overflow, hs_level} !== {1'b1, LW'(0)})
      $display("FAIL ovf_sticky: got ovf=%b lvl=%0d required 1/0", hs_overflow, hs_level);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_inflight();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h055;
    @(negedge clk);
    total_cnt++;
    if (cpu_ready !== 1'b1) $display("FAIL inflight_grant: got %b required 1", cpu_ready);
    else pass_cnt++;
    tick();
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    total_cnt++;
    if (cpu_rvalid !== 1'b0) $display("FAIL inflight_no_rvalid: got %b required 0", cpu_rvalid);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({cpu_ready, cpu_rvalid, hs_rvalid, hs_overflow, ram_we, hs_level, ram_addr, cpu_rdata} !== '0)
      $display("FAIL inflight_outputs: got rdy=%b rv=%b hrv=%b ovf=%b we=%b lvl=%0d addr=%h crd=%h required all 0",
               cpu_ready, cpu_rvalid, hs_rvalid, hs_overflow, ram_we, hs_level, ram_addr, cpu_rdata);
    else pass_cnt++;
    cpu_q.delete();
    reset_n = 1'b1;
    tick();
  endtask

`ifdef HS_HALT_LOCK_EN
  task automatic test_halt_lock();
    int ready_cnt;
    logic [4:0] we_seen;
    ready_cnt = 0;
    we_seen = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h077;
    tick();
    halt_lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) hs_push(1'b1, 12'h500 + 12'(i), 8'h11 * 8'(i + 1));
      else hs_valid = 1'b0;
      @(negedge clk);
      if (cpu_ready === 1'b1) ready_cnt++;
      we_seen[i] = ram_we;
      tick();
    end
    total_cnt++;
    if (ready_cnt !== 0) $display("FAIL halt_cpu_blocked: got %0d grants required 0", ready_cnt);
    else pass_cnt++;
    total_cnt++;
    if (we_seen !== 5'b01110) $display("FAIL halt_bridge_grants: got %b required 01110", we_seen);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (hs_level !== LW'(0)) $display("FAIL halt_level: got %0d required 0", hs_level);
    else pass_cnt++;
    halt_lock = 1'b0;
    cpu_req = 1'b0;
    tick();
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 8'(i) ^ 8'(i >> 4) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'(i >> 4) ^ 8'h5A;
    end
    idle_inputs();
    reset_n = 1'b0;
    test_reset();
    test_bridge_only();
    test_streak();
    test_full_pop();
    test_overflow();
    test_reset_inflight();
`ifdef HS_HALT_LOCK_EN
    test_halt_lock();
`endif
    tick();
    tick();
    total_cnt++;
    if (cpu_q.size() != 0 || hs_q.size() != 0)
      $display("FAIL sb_drained: got cpu=%0d hs=%0d pending required 0/0", cpu_q.size(), hs_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
